// File: rtl/sort_net_pipe.sv
// sort_net_pipe: fully pipelined odd-even transposition sorting network.
// N registered compare-exchange layers; the whole pipe advances in lockstep
// under a single global stall derived from the output handshake.
module sort_net_pipe #(
    parameter int unsigned N      = 9,
    parameter int unsigned DATA_W = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_desc,
    input  logic [N*DATA_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_desc,
    output logic [N*DATA_W-1:0] out_data,
    output logic                busy
);
    localparam int unsigned VecW = N * DATA_W;
    typedef logic [VecW-1:0] vec_t;

    vec_t         stage_q [N];
    vec_t         stage_d [N];
    logic [N-1:0] valid_q;
    logic [N-1:0] valid_d;
    logic [N-1:0] desc_q;
    logic [N-1:0] desc_d;
    logic         advance;

    // Strict greater-than; SIGNED only changes how the bits are interpreted.
    function automatic logic elem_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Global stall: nothing moves while a finished vector waits downstream.
    assign advance  = !valid_q[N-1] || out_ready;
    assign in_ready = advance;

    assign valid_d = {valid_q[N-2:0], in_valid};
    assign desc_d  = {desc_q[N-2:0], in_desc};

    for (genvar s = 0; s < N; s++) begin : g_stage
        vec_t src;
        vec_t dst;
        logic src_desc;

        if (s == 0) begin : g_first
            assign src      = in_data;
            assign src_desc = in_desc;
        end else begin : g_next
            assign src      = stage_q[s-1];
            assign src_desc = desc_q[s-1];
        end

        // Compare-exchange the pairs whose lower index shares this stage's parity;
        // equal keys never swap, which keeps the network stable.
        always_comb begin
            dst = src;
            for (int i = s % 2; i + 1 < int'(N); i += 2) begin
                if (src_desc ? elem_gt(src[(i+1)*DATA_W +: DATA_W], src[i*DATA_W +: DATA_W])
                             : elem_gt(src[i*DATA_W +: DATA_W], src[(i+1)*DATA_W +: DATA_W])) begin
                    dst[i*DATA_W +: DATA_W]     = src[(i+1)*DATA_W +: DATA_W];
                    dst[(i+1)*DATA_W +: DATA_W] = src[i*DATA_W +: DATA_W];
                end
            end
        end

        assign stage_d[s] = dst;
    end

    // Valid bits: cleared by reset, shifted on advance; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
        end
    end

    // Data and direction carry no reset; they are ignored while their slot is invalid.
    always_ff @(posedge clk) begin
        if (advance) begin
            desc_q <= desc_d;
            for (int s = 0; s < int'(N); s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign out_valid = valid_q[N-1];
    assign out_desc  = desc_q[N-1];
    assign out_data  = stage_q[N-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_sort_net_pipe.sv
// tb_sort_net_pipe: directed and scoreboarded checks of sort_net_pipe.
module tb_sort_net_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Element 0 sits at the LSB, so the concatenations list element 8 first.
    localparam logic [287:0] VecA = {32'd4, 32'd5, 32'd6, 32'd2, 32'd8, 32'd1, 32'd9, 32'd3, 32'd7};
    localparam logic [287:0] VecAAsc = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [287:0] VecADesc = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    localparam logic [287:0] VecB = {32'd3, 32'd2, 32'd1, 32'd1, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 32'd5};
    localparam logic [287:0] VecBDesc =
        {32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd5, 32'd5, 32'hFFFFFFFF};
    localparam logic [287:0] VecBAsc =
        {32'hFFFFFFFF, 32'd5, 32'd5, 32'd5, 32'd3, 32'd2, 32'd1, 32'd1, 32'd0};
    localparam logic [287:0] VecS = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'h80000000,
                                     32'h7FFFFFFF, 32'hFFFFFFFF};
    localparam logic [287:0] VecSSigned = {32'h7FFFFFFF, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0,
                                           32'hFFFFFFFF, 32'h80000000};
    localparam logic [287:0] VecSUnsigned = {32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd5,
                                             32'd4, 32'd3, 32'd2, 32'd1, 32'd0};

    logic         rst;
    logic         in_valid, in_desc, out_ready;
    logic [287:0] in_data;
    logic         in_ready, out_valid, out_desc, busy;
    logic [287:0] out_data;
    logic         s_in_ready, s_out_valid, s_out_desc, s_busy;
    logic [287:0] s_out_data;

    logic         sw_valid, sw_desc, sw_ready;
    logic [127:0] sw_data;
    logic         a2_ir, a2_ov, a2_od_desc, a2_busy;
    logic [15:0]  a2_od;
    logic         a3_ir, a3_ov, a3_od_desc, a3_busy;
    logic [23:0]  a3_od;
    logic         a16_ir, a16_ov, a16_od_desc, a16_busy;
    logic [127:0] a16_od;

    sort_net_pipe #(.N(9), .DATA_W(32), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_desc(out_desc),
        .out_data(out_data), .busy(busy)
    );

    sort_net_pipe #(.N(9), .DATA_W(32), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_desc(in_desc),
        .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_desc(s_out_desc), .out_data(s_out_data), .busy(s_busy)
    );

    sort_net_pipe #(.N(2), .DATA_W(8), .SIGNED(1'b0)) u_sw2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(a2_ir), .in_desc(sw_desc),
        .in_data(sw_data[15:0]), .out_valid(a2_ov), .out_ready(sw_ready),
        .out_desc(a2_od_desc), .out_data(a2_od), .busy(a2_busy)
    );

    sort_net_pipe #(.N(3), .DATA_W(8), .SIGNED(1'b0)) u_sw3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(a3_ir), .in_desc(sw_desc),
        .in_data(sw_data[23:0]), .out_valid(a3_ov), .out_ready(sw_ready),
        .out_desc(a3_od_desc), .out_data(a3_od), .busy(a3_busy)
    );

    sort_net_pipe #(.N(16), .DATA_W(8), .SIGNED(1'b0)) u_sw16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(a16_ir), .in_desc(sw_desc),
        .in_data(sw_data), .out_valid(a16_ov), .out_ready(sw_ready),
        .out_desc(a16_od_desc), .out_data(a16_od), .busy(a16_busy)
    );

    // Stable insertion sort over n elements of w bits, element 0 at the LSB.
    function automatic logic [511:0] ref_sort(input logic [511:0] v, input int n, input int w,
                                              input bit sgn, input bit desc);
        logic [31:0]  e [16];
        longint       k [16];
        logic [31:0]  te;
        longint       tk;
        logic [511:0] r;
        logic [511:0] mask;
        mask = (512'd1 << w) - 512'd1;
        for (int i = 0; i < n; i++) begin
            e[i] = 32'((v >> (i * w)) & mask);
            k[i] = longint'({32'd0, e[i]});
            if (sgn && e[i][w-1]) k[i] = k[i] - (longint'(1) << w);
        end
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (k[j-1] >= k[j]) : (k[j-1] <= k[j])) break;
                te = e[j]; e[j] = e[j-1]; e[j-1] = te;
                tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
            end
        end
        r = '0;
        for (int i = 0; i < n; i++) r = r | (512'(e[i]) << (i * w));
        return r;
    endfunction

    // Present one vector on an idle pipe and count cycles until out_valid.
    task automatic send_one(input logic [287:0] v, input logic d, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = v;
        in_desc   = d;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = VecA;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_ignores_in_valid: busy %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_basic_asc;
        int lat;
        send_one(VecA, 1'b0, lat);
        n_total++;
        if (lat != 9) $display("FAIL basic_latency: got %0d want 9", lat);
        else n_pass++;
        n_total++;
        if (out_data !== VecAAsc) $display("FAIL basic_data: got %h want %h", out_data, VecAAsc);
        else n_pass++;
        n_total++;
        if (out_desc !== 1'b0) $display("FAIL basic_desc: got %b want 0", out_desc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL basic_single_emit: out_valid %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_desc_dup;
        int lat;
        send_one(VecB, 1'b1, lat);
        n_total++;
        if (lat != 9) $display("FAIL desc_latency: got %0d want 9", lat);
        else n_pass++;
        n_total++;
        if (out_data !== VecBDesc) $display("FAIL desc_data: got %h want %h", out_data, VecBDesc);
        else n_pass++;
        n_total++;
        if (out_desc !== 1'b1) $display("FAIL desc_flag: got %b want 1", out_desc);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [287:0] vin  [4];
        logic [287:0] vexp [4];
        logic         din  [4];
        vin[0] = VecA; din[0] = 1'b0; vexp[0] = VecAAsc;
        vin[1] = VecB; din[1] = 1'b1; vexp[1] = VecBDesc;
        vin[2] = VecA; din[2] = 1'b1; vexp[2] = VecADesc;
        vin[3] = VecB; din[3] = 1'b0; vexp[3] = VecBAsc;
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = vin[k];
            in_desc  = din[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_data !== vexp[k] || out_desc !== din[k])
                $display("FAIL b2b_vec%0d: got v=%b d=%b %h want v=1 d=%b %h",
                         k, out_valid, out_desc, out_data, din[k], vexp[k]);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_tail: out_valid %b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_signed;
        int lat;
        send_one(VecS, 1'b0, lat);
        n_total++;
        if (s_out_valid !== 1'b1 || s_out_data !== VecSSigned)
            $display("FAIL signed_data: got v=%b %h want v=1 %h", s_out_valid, s_out_data,
                     VecSSigned);
        else n_pass++;
        n_total++;
        if (out_data !== VecSUnsigned)
            $display("FAIL unsigned_data: got %h want %h", out_data, VecSUnsigned);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [287:0] q_data [$];
        logic         q_desc [$];
        logic [287:0] exp_d;
        logic         exp_f;
        logic [287:0] held;
        logic         held_desc;
        int           pushed = 0;
        int           popped = 0;
        int           cyc = 0;
        bit           stalled = 1'b0;
        while ((pushed < 20 || q_data.size() > 0 || out_valid) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                n_total++;
                if (out_data !== held || out_desc !== held_desc)
                    $display("FAIL bp_stable: got %b %h want %b %h", out_desc, out_data,
                             held_desc, held);
                else n_pass++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (pushed < 20) && ($urandom_range(0, 3) != 0);
            in_desc   = 1'($urandom_range(0, 1));
            for (int e = 0; e < 9; e++)
                in_data[e*32 +: 32] = (e % 2 == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
            #1;
            n_total++;
            if (in_ready !== (!out_valid || out_ready))
                $display("FAIL bp_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
            else n_pass++;
            if (out_valid && out_ready) begin
                n_total++;
                if (q_data.size() == 0) begin
                    $display("FAIL bp_extra_output: got %h want none", out_data);
                end else begin
                    exp_d = q_data.pop_front();
                    exp_f = q_desc.pop_front();
                    if (out_data !== exp_d || out_desc !== exp_f)
                        $display("FAIL bp_output%0d: got %b %h want %b %h", popped, out_desc,
                                 out_data, exp_f, exp_d);
                    else n_pass++;
                end
                popped++;
            end
            if (in_valid && in_ready) begin
                q_data.push_back(288'(ref_sort(512'(in_data), 9, 32, 1'b0, in_desc)));
                q_desc.push_back(in_desc);
                pushed++;
            end
            stalled   = out_valid && !out_ready;
            held      = out_data;
            held_desc = out_desc;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_total++;
        if (popped != 20 || q_data.size() != 0 || cyc >= 2000)
            $display("FAIL bp_count: got %0d outputs after %0d cycles want 20", popped, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_midflight;
        int lat;
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = VecA;
            in_desc  = 1'(k % 2);
            rst      = (k == 4);
            @(negedge clk);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_flush: got v=%b busy=%b want 0 0", out_valid, busy);
        else n_pass++;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_total++;
        if (stale != 0) $display("FAIL midreset_stale: got %0d outputs want 0", stale);
        else n_pass++;
        send_one(VecB, 1'b1, lat);
        n_total++;
        if (lat != 9 || out_data !== VecBDesc)
            $display("FAIL midreset_new: got lat %0d %h want lat 9 %h", lat, out_data, VecBDesc);
        else n_pass++;
    endtask

    task automatic test_sweep;
        logic [127:0] h_data  [64];
        logic         h_valid [64];
        logic         h_desc  [64];
        int           nn      [3];
        logic         ov      [3];
        logic         od_desc [3];
        logic [127:0] od      [3];
        logic [127:0] exp_d;
        int           src;
        nn[0] = 2; nn[1] = 3; nn[2] = 16;
        sw_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            sw_valid = (k < 40) && (k != 20);
            sw_desc  = 1'($urandom_range(0, 1));
            for (int e = 0; e < 16; e++)
                sw_data[e*8 +: 8] = (k % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            h_data[k]  = sw_data;
            h_valid[k] = sw_valid;
            h_desc[k]  = sw_desc;
            ov[0] = a2_ov;  od_desc[0] = a2_od_desc;  od[0] = {112'd0, a2_od};
            ov[1] = a3_ov;  od_desc[1] = a3_od_desc;  od[1] = {104'd0, a3_od};
            ov[2] = a16_ov; od_desc[2] = a16_od_desc; od[2] = a16_od;
            for (int j = 0; j < 3; j++) begin
                src = k - nn[j];
                n_total++;
                if (src < 0 || !h_valid[src]) begin
                    if (ov[j] !== 1'b0)
                        $display("FAIL sweep_n%0d_valid_c%0d: got %b want 0", nn[j], k, ov[j]);
                    else n_pass++;
                end else begin
                    exp_d = 128'(ref_sort(512'(h_data[src]), nn[j], 8, 1'b0, h_desc[src]));
                    if (ov[j] !== 1'b1 || od[j] !== exp_d || od_desc[j] !== h_desc[src])
                        $display("FAIL sweep_n%0d_c%0d: got v=%b d=%b %h want v=1 d=%b %h",
                                 nn[j], k, ov[j], od_desc[j], od[j], h_desc[src], exp_d);
                    else n_pass++;
                end
            end
        end
        sw_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_desc   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_desc   = 1'b0;
        sw_data   = '0;
        sw_ready  = 1'b1;
        test_reset();
        test_basic_asc();
        test_desc_dup();
        test_back_to_back();
        test_signed();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
